// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared mode encodings and defaults for the CPU step controller.
// Provides MODE_* codes, the FSM state enum and the default debounce length.
package cpu_ctrl_pkg;

  localparam logic [1:0] MODE_HALT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    S_HALT = MODE_HALT,
    S_RUN  = MODE_RUN,
    S_STEP = MODE_STEP
  } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counter debounce for one raw button.
// Ports: clk, rst (sync, high), btn_raw in; level (debounced), press (1-cycle rise).
import cpu_ctrl_pkg::*;

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // The counter idles at zero while the synced level agrees with the
  // accepted level and runs while they disagree; any return to agreement
  // (a bounce) throws the partial count away.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns divider ticks into 1-cycle CPU enables under run/halt/step.
// Ports: clk, rst, slow_tick_in, btn_run/step/halt, cpu_stall in; cpu_en, mode, step_count, overrun out.
import cpu_ctrl_pkg::*;

module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_tick_in,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic        cpu_stall,
  output logic        cpu_en,
  output logic [1:0]  mode,
  output logic [31:0] step_count,
  output logic        overrun
);

  logic [2:0] levels_unused;
  logic       run_evt;
  logic       step_evt;
  logic       halt_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_run (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_run),
    .level(levels_unused[0]),
    .press(run_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_step (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_step),
    .level(levels_unused[1]),
    .press(step_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W(DB_W)
  ) u_db_halt (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_halt),
    .level(levels_unused[2]),
    .press(halt_evt)
  );

  mode_e mode_q;
  logic  tick_prev;
  logic  pending;
  logic  tick_rise;
  logic  active;

  assign tick_rise = slow_tick_in & ~tick_prev;
  assign active    = (mode_q != S_HALT);
  // rst gating keeps the enable low in the first reset cycle, before
  // the synchronous clear of pending has taken effect.
  assign cpu_en    = pending & ~cpu_stall & active & ~rst;
  assign mode      = mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= S_HALT;
      tick_prev  <= 1'b0;
      pending    <= 1'b0;
      step_count <= '0;
      overrun    <= 1'b0;
    end else begin
      tick_prev <= slow_tick_in;
      if (cpu_en) begin
        step_count <= step_count + 32'd1;
      end

      // A tick on the same edge as an accepted enable becomes the next
      // request; a tick while the request is still blocked is lost.
      if (tick_rise && active) begin
        if (pending && !cpu_en) begin
          overrun <= 1'b1;
        end
        pending <= 1'b1;
      end else if (cpu_en) begin
        pending <= 1'b0;
      end

      // Every entry into HALT drops the request so a later run or step
      // always waits for a fresh tick.
      unique case (mode_q)
        S_HALT: begin
          if (step_evt) begin
            mode_q <= S_STEP;
          end else if (run_evt) begin
            mode_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (halt_evt) begin
            mode_q  <= S_HALT;
            pending <= 1'b0;
          end else if (step_evt) begin
            mode_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (halt_evt) begin
            mode_q  <= S_HALT;
            pending <= 1'b0;
          end else if (run_evt) begin
            mode_q <= S_RUN;
          end else if (cpu_en) begin
            mode_q  <= S_HALT;
            pending <= 1'b0;
          end
        end
        default: begin
          mode_q  <= S_HALT;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: directed and table-driven checks of cpu_step_ctrl.
// Uses DEBOUNCE_CYCLES=4 and a 20-cycle slow tick.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        slow_tick_in;
  logic        btn_run;
  logic        btn_step;
  logic        btn_halt;
  logic        cpu_stall;
  logic        cpu_en;
  logic [1:0]  mode;
  logic [31:0] step_count;
  logic        overrun;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .slow_tick_in(slow_tick_in),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_halt(btn_halt),
    .cpu_stall(cpu_stall),
    .cpu_en(cpu_en),
    .mode(mode),
    .step_count(step_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic auto_tick = 1'b1;
  logic man_tick  = 1'b0;
  logic gen_tick  = 1'b0;
  int   tick_ph   = 0;

  always @(negedge clk) begin
    gen_tick <= (tick_ph < 10);
    tick_ph  <= (tick_ph == 19) ? 0 : tick_ph + 1;
  end

  assign slow_tick_in = auto_tick ? gen_tick : man_tick;

  int   en_pulses = 0;
  int   order_bad = 0;
  logic chk_order = 1'b0;
  logic tick_d    = 1'b0;
  logic rise_last = 1'b0;
  logic en_last   = 1'b0;

  always @(posedge clk) begin
    if (cpu_en) en_pulses <= en_pulses + 1;
    if (chk_order && cpu_en && (!rise_last || en_last))
      order_bad <= order_bad + 1;
    rise_last <= slow_tick_in & ~tick_d;
    tick_d    <= slow_tick_in;
    en_last   <= cpu_en;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic        tick;
    logic        stall;
    logic        en;
    logic        ovr;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int e0;
    int guard;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd3};

    rst       = 1'b1;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_halt  = 1'b0;
    cpu_stall = 1'b0;

    // 1: reset and idle
    @(negedge clk);
    #1 chk("rst_en", 32'(cpu_en), 32'd0);
    cyc(3);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_cnt", step_count, 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    e0 = en_pulses;
    cyc(100);
    chk("idle_en", 32'(en_pulses - e0), 32'd0);
    chk("idle_mode", 32'(mode), 32'd0);
    chk("idle_cnt", step_count, 32'd0);
    chk("idle_ovr", 32'(overrun), 32'd0);

    // 2: run button, then 5 tick periods
    guard = 0;
    @(negedge clk);
    while (tick_ph != 5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    btn_run = 1'b1;
    cyc(6);
    chk("run_early", 32'(mode), 32'd0);
    cyc(1);
    chk("run_mode", 32'(mode), 32'd1);
    e0 = en_pulses;
    chk_order = 1'b1;
    cyc(3);
    btn_run = 1'b0;
    cyc(97);
    chk_order = 1'b0;
    chk("run_pulses", 32'(en_pulses - e0), 32'd5);
    chk("run_cnt", step_count, 32'd5);
    chk("run_order", 32'(order_bad), 32'd0);
    chk("run_mode2", 32'(mode), 32'd1);

    // 3: single step from HALT
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    e0 = en_pulses;
    btn_step = 1'b1;
    cyc(7);
    chk("step_mode", 32'(mode), 32'd2);
    cyc(3);
    btn_step = 1'b0;
    cyc(60);
    chk("step_pulses", 32'(en_pulses - e0), 32'd1);
    chk("step_back", 32'(mode), 32'd0);
    chk("step_cnt", step_count, 32'd1);

    // 4: bouncing run button
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      btn_run = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        cyc(1);
        chk("bounce_mode", 32'(mode), 32'd0);
      end
    end
    btn_run = 1'b1;
    cyc(6);
    chk("bounce_early", 32'(mode), 32'd0);
    cyc(1);
    chk("bounce_run", 32'(mode), 32'd1);
    cyc(4);
    btn_run = 1'b0;
    cyc(10);
    chk("bounce_hold", 32'(mode), 32'd1);

    // 5: request/stall/overrun table in RUN with manual ticks
    rst = 1'b1;
    auto_tick = 1'b0;
    man_tick = 1'b0;
    cyc(2);
    rst = 1'b0;
    btn_run = 1'b1;
    cyc(7);
    chk("tbl_run", 32'(mode), 32'd1);
    btn_run = 1'b0;
    cyc(8);
    for (int i = 0; i < 12; i++) begin
      man_tick  = tbl[i].tick;
      cpu_stall = tbl[i].stall;
      #1;
      chk($sformatf("tbl%0d_en", i), 32'(cpu_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'(tbl[i].ovr));
      chk($sformatf("tbl%0d_cnt", i), step_count, tbl[i].cnt);
      @(negedge clk);
    end

    // 6a: halt+step together while a request is pending
    cpu_stall = 1'b1;
    man_tick = 1'b1;
    cyc(1);
    chk("pend_stall_en", 32'(cpu_en), 32'd0);
    btn_halt = 1'b1;
    btn_step = 1'b1;
    cyc(6);
    chk("prio_early", 32'(mode), 32'd1);
    cyc(1);
    chk("prio_halt", 32'(mode), 32'd0);
    btn_halt = 1'b0;
    btn_step = 1'b0;
    cyc(8);
    cpu_stall = 1'b0;
    e0 = en_pulses;
    btn_run = 1'b1;
    cyc(7);
    chk("prio_rerun", 32'(mode), 32'd1);
    btn_run = 1'b0;
    cyc(6);
    chk("pend_cleared", 32'(en_pulses - e0), 32'd0);
    chk("pend_cnt", step_count, 32'd3);

    // 6b: reset with a request pending
    cpu_stall = 1'b1;
    man_tick = 1'b0;
    cyc(1);
    man_tick = 1'b1;
    cyc(1);
    rst = 1'b1;
    cpu_stall = 1'b0;
    #1 chk("midrst_en", 32'(cpu_en), 32'd0);
    cyc(2);
    rst = 1'b0;
    e0 = en_pulses;
    cyc(10);
    chk("midrst_pulses", 32'(en_pulses - e0), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_cnt", step_count, 32'd0);
    chk("midrst_ovr", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
